// File: rtl/noc_packet_checker.sv
// noc_packet_checker: sink endpoint on the NoC local ejection port.
// Throttles the router with programmable backpressure and checks framing, destination, length and payload.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif
`ifndef Noc_Point_H
`define Noc_Point_H 32
`endif

module noc_packet_checker #(
    parameter logic [`Noc_ID_X_Width-1:0] X_ID           = '0,
    parameter logic [`Noc_ID_Y_Width-1:0] Y_ID           = '0,
    parameter int unsigned                EXP_DATA_FLITS = 11,
    parameter logic [`Noc_Data_Width-1:0] DATA_PATTERN   = '1,
    parameter int unsigned                STALL_PERIOD   = 0,
    parameter int unsigned                STALL_LEN      = 0
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst_n,
    input  logic                       receive_valid,
    output logic                       receive_ready,
    input  logic [`Noc_Data_Width-1:0] receive_flit,
    input  logic                       receive_is_header,
    input  logic                       receive_is_tail,
    output logic                       pkt_done,
    output logic                       pkt_ok,
    output logic [`Noc_ID_X_Width-1:0] last_src_x,
    output logic [`Noc_ID_Y_Width-1:0] last_src_y,
    output logic [15:0]                pkt_count,
    output logic [15:0]                err_count,
    output logic [3:0]                 err_flags
);

    localparam int XW  = `Noc_ID_X_Width;
    localparam int YW  = `Noc_ID_Y_Width;
    localparam int IDW = XW + YW;
    localparam int SCW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    localparam logic [3:0]     ERR_DEST  = 4'b0001;
    localparam logic [3:0]     ERR_LEN   = 4'b0010;
    localparam logic [3:0]     ERR_DATA  = 4'b0100;
    localparam logic [3:0]     ERR_FRAME = 4'b1000;
    localparam logic [IDW-1:0] OWN_ID    = {X_ID, Y_ID};

    typedef enum logic {
        IDLE,
        BODY
    } state_t;

    state_t         state;
    logic [SCW-1:0] stall_cnt;
    logic [IDW-1:0] src_q;
    logic [7:0]     data_cnt;
    logic [3:0]     pkt_err;

    logic           accept;
    logic [IDW-1:0] flit_src;
    logic [IDW-1:0] flit_dst;
    logic           start_evt;
    logic           abort_evt;
    logic           stray_evt;
    logic           complete_evt;
    logic           data_evt;
    logic [3:0]     hdr_err;
    logic [3:0]     done_err;
    logic [3:0]     flags_nxt;
    logic [IDW-1:0] done_src;
    logic [15:0]    err_count_step;
    logic [15:0]    err_count_nxt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign accept   = receive_valid & receive_ready;
    assign flit_src = receive_flit[`Noc_Point_H-1 -: IDW];
    assign flit_dst = receive_flit[`Noc_Point_H-1-IDW -: IDW];
    assign hdr_err  = (flit_dst != OWN_ID) ? ERR_DEST : 4'b0000;

    // Ready lags the stall counter by one cycle so it comes straight from a flop.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            stall_cnt     <= '0;
            receive_ready <= 1'b1;
        end else if (STALL_PERIOD == 0) begin
            stall_cnt     <= '0;
            receive_ready <= 1'b1;
        end else begin
            stall_cnt     <= (stall_cnt == SCW'(STALL_PERIOD - 1)) ? '0 : stall_cnt + SCW'(1);
            receive_ready <= (stall_cnt >= SCW'(STALL_LEN));
        end
    end

    // A header arriving mid-packet both aborts the old packet and may complete a zero-length one,
    // so err_count can step twice in a single cycle.
    always_comb begin
        start_evt    = 1'b0;
        abort_evt    = 1'b0;
        stray_evt    = 1'b0;
        complete_evt = 1'b0;
        data_evt     = 1'b0;
        done_err     = 4'b0000;
        done_src     = flit_src;
        flags_nxt    = err_flags;
        if (accept) begin
            if (receive_is_header) begin
                start_evt = 1'b1;
                if (state == BODY) begin
                    abort_evt = 1'b1;
                    flags_nxt = flags_nxt | pkt_err | ERR_FRAME;
                end
                if (receive_is_tail) begin
                    complete_evt = 1'b1;
                    done_err     = hdr_err | ((EXP_DATA_FLITS != 0) ? ERR_LEN : 4'b0000);
                end
            end else if (state == IDLE) begin
                stray_evt = 1'b1;
                flags_nxt = flags_nxt | ERR_FRAME;
            end else if (receive_is_tail) begin
                complete_evt = 1'b1;
                done_src     = src_q;
                done_err     = pkt_err
                             | ((flit_src != src_q) ? ERR_FRAME : 4'b0000)
                             | ((32'(data_cnt) != EXP_DATA_FLITS) ? ERR_LEN : 4'b0000);
            end else begin
                data_evt = 1'b1;
            end
        end
        if (complete_evt) begin
            flags_nxt = flags_nxt | done_err;
        end
        err_count_step = (abort_evt | stray_evt) ? sat_inc(err_count) : err_count;
        err_count_nxt  = (complete_evt && (done_err != 4'b0000)) ? sat_inc(err_count_step)
                                                                 : err_count_step;
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state      <= IDLE;
            src_q      <= '0;
            data_cnt   <= '0;
            pkt_err    <= '0;
            pkt_done   <= 1'b0;
            pkt_ok     <= 1'b0;
            last_src_x <= '0;
            last_src_y <= '0;
            pkt_count  <= '0;
            err_count  <= '0;
            err_flags  <= '0;
        end else begin
            pkt_done  <= complete_evt;
            pkt_ok    <= complete_evt && (done_err == 4'b0000);
            err_count <= err_count_nxt;
            err_flags <= flags_nxt;
            if (complete_evt) begin
                {last_src_x, last_src_y} <= done_src;
                if (done_err == 4'b0000) begin
                    pkt_count <= sat_inc(pkt_count);
                end
            end
            if (start_evt) begin
                src_q    <= flit_src;
                data_cnt <= '0;
                pkt_err  <= hdr_err;
                state    <= receive_is_tail ? IDLE : BODY;
            end else if (complete_evt) begin
                state <= IDLE;
            end else if (data_evt) begin
                if (data_cnt != 8'hFF) begin
                    data_cnt <= data_cnt + 8'd1;
                end
                if (receive_flit != DATA_PATTERN) begin
                    pkt_err <= pkt_err | ERR_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_packet_checker.sv
// Bench for noc_packet_checker: a checker without stalls is compared every cycle against a packet-level
// model, a second instance with 4/2 backpressure receives ten packets and has its ready pattern checked.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif
`ifndef Noc_Point_H
`define Noc_Point_H 32
`endif

module tb_noc_packet_checker;

    localparam int              DW   = `Noc_Data_Width;
    localparam logic [3:0]      MY_X = 4'd1;
    localparam logic [3:0]      MY_Y = 4'd2;
    localparam logic [3:0]      SX   = 4'd2;
    localparam logic [3:0]      SY   = 4'd3;
    localparam int              EXP  = 11;
    localparam logic [DW-1:0]   ONES = '1;

    logic noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    logic          a_rst_n = 1'b0;
    logic          a_valid = 1'b0;
    logic [DW-1:0] a_flit  = '0;
    logic          a_hdr   = 1'b0;
    logic          a_tail  = 1'b0;
    logic          a_ready, a_done, a_ok;
    logic [3:0]    a_src_x, a_src_y, a_err_flags;
    logic [15:0]   a_pkt_count, a_err_count;

    logic          b_rst_n = 1'b0;
    logic          b_valid = 1'b0;
    logic [DW-1:0] b_flit  = '0;
    logic          b_hdr   = 1'b0;
    logic          b_tail  = 1'b0;
    logic          b_ready, b_done, b_ok;
    logic [3:0]    b_src_x, b_src_y, b_err_flags;
    logic [15:0]   b_pkt_count, b_err_count;

    int checks = 0;
    int failures = 0;
    int b_edges = 0;
    int b_done_seen = 0;

    logic          exp_done = 1'b0;
    logic          exp_ok = 1'b0;
    logic [3:0]    exp_src_x = '0;
    logic [3:0]    exp_src_y = '0;
    logic [15:0]   exp_pkt_count = '0;
    logic [15:0]   exp_err_count = '0;
    logic [3:0]    exp_flags = '0;
    bit            m_in_pkt = 1'b0;
    logic [DW-1:0] m_hdr = '0;
    logic [DW-1:0] m_body[$];

    noc_packet_checker #(
        .X_ID(MY_X), .Y_ID(MY_Y), .EXP_DATA_FLITS(EXP), .DATA_PATTERN(ONES),
        .STALL_PERIOD(0), .STALL_LEN(0)
    ) dut_a (
        .noc_clk(noc_clk), .noc_rst_n(a_rst_n),
        .receive_valid(a_valid), .receive_ready(a_ready), .receive_flit(a_flit),
        .receive_is_header(a_hdr), .receive_is_tail(a_tail),
        .pkt_done(a_done), .pkt_ok(a_ok), .last_src_x(a_src_x), .last_src_y(a_src_y),
        .pkt_count(a_pkt_count), .err_count(a_err_count), .err_flags(a_err_flags)
    );

    noc_packet_checker #(
        .X_ID(MY_X), .Y_ID(MY_Y), .EXP_DATA_FLITS(EXP), .DATA_PATTERN(ONES),
        .STALL_PERIOD(4), .STALL_LEN(2)
    ) dut_b (
        .noc_clk(noc_clk), .noc_rst_n(b_rst_n),
        .receive_valid(b_valid), .receive_ready(b_ready), .receive_flit(b_flit),
        .receive_is_header(b_hdr), .receive_is_tail(b_tail),
        .pkt_done(b_done), .pkt_ok(b_ok), .last_src_x(b_src_x), .last_src_y(b_src_y),
        .pkt_count(b_pkt_count), .err_count(b_err_count), .err_flags(b_err_flags)
    );

    function automatic logic [DW-1:0] mk_hdr(input logic [3:0] sx, sy, dx, dy);
        return {sx, sy, dx, dy, 16'h0000};
    endfunction

    function automatic logic [DW-1:0] mk_tail(input logic [3:0] sx, sy);
        return {sx, sy, 24'h000000};
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Packet-level model: the packet's flits are collected and judged as a whole when it ends.
    function automatic logic [3:0] pkt_errs(input bit with_len);
        logic [3:0] e;
        int n;
        e = 4'b0000;
        n = (m_body.size() > 255) ? 255 : m_body.size();
        if (m_hdr[23:16] != {MY_X, MY_Y}) e[0] = 1'b1;
        if (with_len && (n != EXP)) e[1] = 1'b1;
        foreach (m_body[i]) if (m_body[i] != ONES) e[2] = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        exp_done = 1'b0; exp_ok = 1'b0; exp_src_x = '0; exp_src_y = '0;
        exp_pkt_count = '0; exp_err_count = '0; exp_flags = '0;
        m_in_pkt = 1'b0; m_hdr = '0; m_body.delete();
    endtask

    task automatic model_abort(input logic [3:0] e);
        exp_err_count = sat16(exp_err_count);
        exp_flags = exp_flags | e;
    endtask

    task automatic model_close(input logic [3:0] e);
        exp_done = 1'b1;
        exp_ok = (e == 4'b0000);
        exp_src_x = m_hdr[31:28];
        exp_src_y = m_hdr[27:24];
        if (e == 4'b0000) exp_pkt_count = sat16(exp_pkt_count);
        else model_abort(e);
    endtask

    task automatic model_step(input logic v, input logic [DW-1:0] f, input logic h, input logic t);
        logic [3:0] e;
        if (!a_rst_n) begin
            model_reset();
            return;
        end
        exp_done = 1'b0;
        exp_ok = 1'b0;
        if (!v) return;
        if (h) begin
            if (m_in_pkt) model_abort(pkt_errs(1'b0) | 4'b1000);
            m_hdr = f;
            m_body.delete();
            m_in_pkt = 1'b1;
            if (t) begin
                model_close(pkt_errs(1'b1));
                m_in_pkt = 1'b0;
            end
        end else if (!m_in_pkt) begin
            model_abort(4'b1000);
        end else if (t) begin
            e = pkt_errs(1'b1) | ((f[31:24] != m_hdr[31:24]) ? 4'b1000 : 4'b0000);
            model_close(e);
            m_in_pkt = 1'b0;
        end else begin
            m_body.push_back(f);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [DW-1:0] f, input logic h, input logic t);
        a_valid = v; a_flit = f; a_hdr = h; a_tail = t;
        @(posedge noc_clk);
        model_step(v, f, h, t);
        #1;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic send_pkt_a(input logic [3:0] sx, sy, dx, dy, input int n, input int bad);
        apply_stimulus(1'b1, mk_hdr(sx, sy, dx, dy), 1'b1, 1'b0);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, (i == bad) ? '0 : ONES, 1'b0, 1'b0);
        apply_stimulus(1'b1, mk_tail(sx, sy), 1'b0, 1'b1);
    endtask

    task automatic reset_a();
        a_rst_n = 1'b0;
        model_reset();
        #1;
        check_output("rst_pkt_count", 32'(a_pkt_count), 0);
        check_output("rst_err_count", 32'(a_err_count), 0);
        check_output("rst_err_flags", 32'(a_err_flags), 0);
        check_output("rst_ready", 32'(a_ready), 1);
        idle_a(2);
        a_rst_n = 1'b1;
    endtask

    task automatic send_b(input logic [DW-1:0] f, input logic h, input logic t);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        b_valid = 1'b1; b_flit = f; b_hdr = h; b_tail = t;
        while (!acc && guard < 20) begin
            @(negedge noc_clk);
            acc = b_ready;
            @(posedge noc_clk);
            #1;
            guard++;
        end
        if (!acc) check_output("b_accept_timeout", 0, 1);
    endtask

    initial forever begin
        @(posedge noc_clk or negedge b_rst_n);
        if (!b_rst_n) b_edges = 0;
        else b_edges++;
    end

    // One compare point per cycle, on the falling edge, for both instances.
    initial forever begin
        logic b_exp_ready;
        @(negedge noc_clk);
        check_output("a_ready", 32'(a_ready), 1);
        check_output("a_pkt_done", 32'(a_done), 32'(exp_done));
        check_output("a_pkt_ok", 32'(a_ok), 32'(exp_ok));
        check_output("a_last_src_x", 32'(a_src_x), 32'(exp_src_x));
        check_output("a_last_src_y", 32'(a_src_y), 32'(exp_src_y));
        check_output("a_pkt_count", 32'(a_pkt_count), 32'(exp_pkt_count));
        check_output("a_err_count", 32'(a_err_count), 32'(exp_err_count));
        check_output("a_err_flags", 32'(a_err_flags), 32'(exp_flags));
        b_exp_ready = (b_edges == 0) ? 1'b1 : (((b_edges - 1) % 4) >= 2);
        check_output("b_ready", 32'(b_ready), 32'(b_exp_ready));
        if (b_done) begin
            b_done_seen++;
            check_output("b_pkt_ok", 32'(b_ok), 1);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge noc_clk);
        #1;
        b_rst_n = 1'b1;

        $display("[TB] backpressure: ten packets into the 4/2 stalling checker");
        for (int p = 0; p < 10; p++) begin
            send_b(mk_hdr(SX, SY, MY_X, MY_Y), 1'b1, 1'b0);
            for (int i = 0; i < EXP; i++) send_b(ONES, 1'b0, 1'b0);
            send_b(mk_tail(SX, SY), 1'b0, 1'b1);
        end
        b_valid = 1'b0;

        $display("[TB] clean packet");
        a_rst_n = 1'b1;
        idle_a(2);
        send_pkt_a(SX, SY, MY_X, MY_Y, EXP, -1);
        check_output("clean_done_pulse", 32'(a_done), 1);
        check_output("clean_ok", 32'(a_ok), 1);
        idle_a(1);
        check_output("clean_done_cleared", 32'(a_done), 0);
        check_output("clean_pkt_count", 32'(a_pkt_count), 1);
        check_output("clean_err_flags", 32'(a_err_flags), 0);
        check_output("clean_src_x", 32'(a_src_x), 2);
        check_output("clean_src_y", 32'(a_src_y), 3);

        $display("[TB] wrong destination");
        reset_a();
        send_pkt_a(SX, SY, 4'd3, 4'd3, EXP, -1);
        check_output("dest_done", 32'(a_done), 1);
        check_output("dest_ok", 32'(a_ok), 0);
        idle_a(1);
        check_output("dest_flags", 32'(a_err_flags), 1);
        check_output("dest_err_count", 32'(a_err_count), 1);
        check_output("dest_pkt_count", 32'(a_pkt_count), 0);

        $display("[TB] length and data errors");
        reset_a();
        send_pkt_a(SX, SY, MY_X, MY_Y, 10, -1);
        idle_a(1);
        check_output("len_flags", 32'(a_err_flags), 2);
        send_pkt_a(SX, SY, MY_X, MY_Y, EXP, 4);
        idle_a(1);
        check_output("data_flags", 32'(a_err_flags), 6);
        check_output("data_err_count", 32'(a_err_count), 2);
        check_output("data_pkt_count", 32'(a_pkt_count), 0);

        $display("[TB] framing");
        reset_a();
        apply_stimulus(1'b1, mk_tail(SX, SY), 1'b0, 1'b1);
        check_output("stray_no_done", 32'(a_done), 0);
        idle_a(1);
        check_output("stray_flags", 32'(a_err_flags), 8);
        check_output("stray_err_count", 32'(a_err_count), 1);
        apply_stimulus(1'b1, mk_hdr(SX, SY, MY_X, MY_Y), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, ONES, 1'b0, 1'b0);
        send_pkt_a(SX, SY, MY_X, MY_Y, EXP, -1);
        idle_a(1);
        check_output("resync_err_count", 32'(a_err_count), 2);
        check_output("resync_pkt_count", 32'(a_pkt_count), 1);

        $display("[TB] reset mid-packet");
        apply_stimulus(1'b1, mk_hdr(SX, SY, MY_X, MY_Y), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, ONES, 1'b0, 1'b0);
        reset_a();
        send_pkt_a(SX, SY, MY_X, MY_Y, EXP, -1);
        idle_a(1);
        check_output("midrst_pkt_count", 32'(a_pkt_count), 1);
        check_output("midrst_err_count", 32'(a_err_count), 0);
        check_output("midrst_flags", 32'(a_err_flags), 0);

        $display("[TB] zero-length packets");
        reset_a();
        apply_stimulus(1'b1, mk_hdr(SX, SY, MY_X, MY_Y), 1'b1, 1'b1);
        check_output("zero_done", 32'(a_done), 1);
        check_output("zero_ok", 32'(a_ok), 0);
        idle_a(1);
        check_output("zero_flags", 32'(a_err_flags), 2);
        apply_stimulus(1'b1, mk_hdr(SX, SY, MY_X, MY_Y), 1'b1, 1'b0);
        apply_stimulus(1'b1, ONES, 1'b0, 1'b0);
        apply_stimulus(1'b1, ONES, 1'b0, 1'b0);
        apply_stimulus(1'b1, mk_hdr(SX, SY, MY_X, MY_Y), 1'b1, 1'b1);
        idle_a(1);
        check_output("zero_body_err_count", 32'(a_err_count), 3);
        check_output("zero_body_flags", 32'(a_err_flags), 10);
        send_pkt_a(4'd3, 4'd1, MY_X, MY_Y, EXP, -1);
        idle_a(1);
        check_output("newsrc_pkt_count", 32'(a_pkt_count), 1);
        check_output("newsrc_src_x", 32'(a_src_x), 3);
        check_output("newsrc_src_y", 32'(a_src_y), 1);

        idle_a(2);
        check_output("b_pkt_count", 32'(b_pkt_count), 10);
        check_output("b_err_count", 32'(b_err_count), 0);
        check_output("b_err_flags", 32'(b_err_flags), 0);
        check_output("b_done_pulses", 32'(b_done_seen), 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_packet_checker.md
Name: noc_packet_checker

Overview:
- Sink-side endpoint for the NoC local port; consumes the header/data/tail packets generated by the traffic-source node.
- Applies programmable backpressure, checks framing, destination, payload length and payload pattern, and keeps per-run statistics.
- Sits on the router's local ejection port in fabric testbenches and in on-chip self-test.

Parameters:
- X_ID, 0, own X coordinate (`Noc_ID_X_Width bits)
- Y_ID, 0, own Y coordinate (`Noc_ID_Y_Width bits)
- EXP_DATA_FLITS, 11, expected data flits per packet, excluding header and tail
- DATA_PATTERN, all ones (`Noc_Data_Width bits), required value of every data flit
- STALL_PERIOD, 0, backpressure period in cycles; 0 disables stalling
- STALL_LEN, 0, cycles per period that receive_ready is low; must be less than STALL_PERIOD

Ports:
- noc_clk  in  1  clock
- noc_rst_n  in  1  reset; asynchronous assert, active-low
- receive_valid  in  1  flit valid from router
- receive_ready  out  1  checker can accept a flit
- receive_flit  in  `Noc_Data_Width  flit payload
- receive_is_header  in  1  flit is a header
- receive_is_tail  in  1  flit is a tail
- pkt_done  out  1  one-cycle pulse: a packet completed (tail accepted)
- pkt_ok  out  1  valid with pkt_done; 1 = packet had no error
- last_src_x  out  `Noc_ID_X_Width  source X of the last completed packet
- last_src_y  out  `Noc_ID_Y_Width  source Y of the last completed packet
- pkt_count  out  16  packets completed without error; saturates at 16'hFFFF
- err_count  out  16  packets completed or aborted with an error; saturates at 16'hFFFF
- err_flags  out  4  sticky flags: [0] dest, [1] len, [2] data, [3] frame

Behaviour:
- Reset values: all outputs 0, except receive_ready = 1. State = IDLE; stall counter = 0.
- Accept condition: a flit is accepted only when receive_valid & receive_ready. Flits with receive_ready = 0 are ignored and not stored.
- Header field layout:
  - SRC = receive_flit[`Noc_Point_H-1 -: XW+YW], upper XW bits = X.
  - DST = the next XW+YW bits immediately below SRC.
- receive_ready generation:
  - STALL_PERIOD = 0: ready is constant 1.
  - Otherwise a free-running counter counts 0..STALL_PERIOD-1 and wraps. Ready = 0 when counter < STALL_LEN, else 1.
  - Ready is registered and independent of packet state.
- States:
  - IDLE
    - Accepted header: latch SRC, clear data counter and the per-packet error vector, go to BODY. If DST != {X_ID,Y_ID}, set per-packet dest error.
    - Header with is_tail also set: treat as a zero-length packet and complete immediately (len error if EXP_DATA_FLITS != 0).
    - Accepted data or tail: set err_flags[3], increment err_count, stay IDLE. No pkt_done.
  - BODY
    - Accepted data flit: data counter +1, saturating at 255. If the flit != DATA_PATTERN, set per-packet data error.
    - Accepted tail:
      - Tail SRC != latched SRC sets frame error.
      - Counter != EXP_DATA_FLITS sets len error.
      - Then complete and go to IDLE.
    - Accepted header: frame error on the current packet; abort it (err_count +1, no pkt_done), then process the new header exactly as in IDLE (resync).
- Completion (registered; visible the cycle after the tail is accepted):
  - pkt_done = 1, last_src_x/y updated.
  - Per-packet error vector clear: pkt_ok = 1, pkt_count +1.
  - Otherwise: pkt_ok = 0, err_count +1, err_flags |= vector.
- Output timing: pkt_ok and pkt_done are 0 in all other cycles. Each packet bumps exactly one of pkt_count or err_count.
- Flags: err_flags is sticky until reset.
- Reset: asserting noc_rst_n low mid-packet returns all state to reset values immediately; the partial packet is neither counted nor flagged.
- Both is_header and is_tail set in BODY: treated as header (abort + resync), then completed as a zero-length packet.

Test Plan:
- Clean packet: 1 packet to (X_ID,Y_ID)=(1,2), 11 all-ones data flits, STALL_PERIOD=0 -> pkt_done pulse one cycle after tail, pkt_ok=1, pkt_count=1, err_flags=0, last_src = sender's ID.
- Backpressure: STALL_PERIOD=4, STALL_LEN=2, sender holds valid -> ready pattern 0,0,1,1 repeating; 10 packets complete, pkt_count=10, err_count=0.
- Wrong destination: header DST=(3,3) at node (1,2) -> pkt_ok=0, err_flags=4'b0001, err_count=1, pkt_count=0.
- Length and data errors:
  - 10 data flits -> err_flags[1] set.
  - Next packet with one flit = 0 -> err_flags[2] set; err_count=2.
- Framing:
  - Tail while IDLE -> err_flags[3] set, err_count=1, no pkt_done.
  - Header, 5 data flits, new header, 11 data flits, tail -> err_count=2, pkt_count=1.
- Reset mid-packet: reset after header + 3 data flits, then a clean packet -> counters 0 after reset; pkt_count=1 at end, err_flags=0.
